mfp_irq_ctrl: RTL and testbench

Interrupt controller stage of the MFP68901, directly downstream of the timer blocks. It consumes per-channel event pulses (timer T_O_PULSE outputs, GPIP edges, USART events), keeps the enable/pending/in-service/mask registers (IERA/B, IPRA/B, ISRA/B, IMRA/B) and the vector register (VR), and drives the CPU interrupt request. On acknowledge it returns the vector. 16 channels; channel 15 has the highest priority.

---
 rtl/mfp_irq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mfp_irq_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_irq_ctrl.sv
// -----------------------------------------------------------------------------
// mfp_irq_ctrl
//   Interrupt controller stage of the MFP68901. Collects per-channel event
//   pulses (timer outputs, GPIP edges, USART events), maintains the enable,
//   pending, in-service and mask registers plus the vector register, drives
//   the CPU interrupt request and returns a vector on acknowledge.
//   16 channels; channel 15 has the highest priority. The "A" registers hold
//   channels 15..8, the "B" registers hold channels 7..0.
//
// Ports
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   REG_SEL    register select (0 IERA, 1 IERB, 2 IPRA, 3 IPRB, 4 ISRA,
//              5 ISRB, 6 IMRA, 7 IMRB, 8 VR, others unused)
//   REG_WE     one-cycle write strobe
//   DAT_I      write data
//   DAT_O      combinational read data for REG_SEL (unused selects read 0)
//   IRQ_IN     channel event inputs, rising edges become events
//   IACK       one-cycle interrupt acknowledge strobe
//   IRQ_N      registered active-low interrupt request
//   VEC_O      vector returned by the last successful acknowledge
//   VEC_VALID  one-cycle strobe, VEC_O has just been updated
//   SPURIOUS   one-cycle strobe, an acknowledge found no qualifying request
// -----------------------------------------------------------------------------
module mfp_irq_ctrl #(
  parameter logic [7:0] VR_RESET = 8'h00
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  REG_SEL,
  input  logic        REG_WE,
  input  logic [7:0]  DAT_I,
  output logic [7:0]  DAT_O,
  input  logic [15:0] IRQ_IN,
  input  logic        IACK,
  output logic        IRQ_N,
  output logic [7:0]  VEC_O,
  output logic        VEC_VALID,
  output logic        SPURIOUS
);

  localparam logic [3:0] SEL_IERA = 4'd0;
  localparam logic [3:0] SEL_IERB = 4'd1;
  localparam logic [3:0] SEL_IPRA = 4'd2;
  localparam logic [3:0] SEL_IPRB = 4'd3;
  localparam logic [3:0] SEL_ISRA = 4'd4;
  localparam logic [3:0] SEL_ISRB = 4'd5;
  localparam logic [3:0] SEL_IMRA = 4'd6;
  localparam logic [3:0] SEL_IMRB = 4'd7;
  localparam logic [3:0] SEL_VR   = 4'd8;

  // Register state
  logic [15:0] ier_q, ier_d;
  logic [15:0] ipr_q, ipr_d;
  logic [15:0] isr_q, isr_d;
  logic [15:0] imr_q, imr_d;
  logic [7:0]  vr_q,  vr_d;
  logic [15:0] irq_in_q, irq_in_d;
  logic        irq_n_q, irq_n_d;
  logic [7:0]  vec_q, vec_d;
  logic        vec_valid_q, vec_valid_d;
  logic        spurious_q, spurious_d;

  // Decision signals
  logic [15:0] ev;
  logic [15:0] req;
  logic        win_found;
  logic [3:0]  win_idx;
  logic        isr_any;
  logic [3:0]  isr_top;
  logic        qualify;
  logic        ack_hit;

  assign ev  = IRQ_IN & ~irq_in_q;
  assign req = ipr_q & imr_q;

  // Highest-set-bit searches. An ascending loop lets the last (highest)
  // set bit overwrite any lower one.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    isr_any   = 1'b0;
    isr_top   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = 4'(i);
      end
      if (isr_q[i]) begin
        isr_any = 1'b1;
        isr_top = 4'(i);
      end
    end
  end

  // With software end-of-interrupt (S = 1) a request must outrank every
  // channel already in service. With S = 0 the ISR is held at zero.
  assign qualify = win_found & (~vr_q[3] | ~isr_any | (win_idx > isr_top));
  assign ack_hit = IACK & qualify;

  // Next-state: acknowledge update first, then register writes, then event
  // sets. The order of the statements is the priority order.
  // NOTE: blocking assignments in always_comb are evaluated in order, so a
  // later assignment to the same bit deliberately overrides an earlier one.
  always_comb begin
    ier_d    = ier_q;
    ipr_d    = ipr_q;
    isr_d    = isr_q;
    imr_d    = imr_q;
    vr_d     = vr_q;
    vec_d    = vec_q;
    irq_in_d = IRQ_IN;

    if (ack_hit) begin
      ipr_d[win_idx] = 1'b0;
      if (vr_q[3]) isr_d[win_idx] = 1'b1;
      vec_d = {vr_q[7:4], win_idx};
    end

    if (REG_WE) begin
      case (REG_SEL)
        SEL_IERA: begin
          ier_d[15:8] = DAT_I;
          ipr_d[15:8] = ipr_d[15:8] & DAT_I;
        end
        SEL_IERB: begin
          ier_d[7:0] = DAT_I;
          ipr_d[7:0] = ipr_d[7:0] & DAT_I;
        end
        // Pending and in-service writes can only clear bits.
        SEL_IPRA: ipr_d[15:8] = ipr_d[15:8] & DAT_I;
        SEL_IPRB: ipr_d[7:0]  = ipr_d[7:0]  & DAT_I;
        SEL_ISRA: isr_d[15:8] = isr_d[15:8] & DAT_I;
        SEL_ISRB: isr_d[7:0]  = isr_d[7:0]  & DAT_I;
        SEL_IMRA: imr_d[15:8] = DAT_I;
        SEL_IMRB: imr_d[7:0]  = DAT_I;
        SEL_VR: begin
          vr_d = DAT_I;
          if (!DAT_I[3]) isr_d = '0;
        end
        default: ;
      endcase
    end

    // A new event on an enabled channel beats any clear in the same cycle,
    // including the clear from acknowledging that very channel.
    ipr_d = ipr_d | (ev & ier_q);
  end

  // Output strobes and request, all registered.
  always_comb begin
    irq_n_d     = ~qualify;
    vec_valid_d = ack_hit;
    spurious_d  = IACK & ~qualify;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ier_q       <= '0;
      ipr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      vr_q        <= VR_RESET;
      irq_in_q    <= '0;
      irq_n_q     <= 1'b1;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      ier_q       <= ier_d;
      ipr_q       <= ipr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      vr_q        <= vr_d;
      irq_in_q    <= irq_in_d;
      irq_n_q     <= irq_n_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      spurious_q  <= spurious_d;
    end
  end

  // Register read-back
  always_comb begin
    DAT_O = 8'h00;
    case (REG_SEL)
      SEL_IERA: DAT_O = ier_q[15:8];
      SEL_IERB: DAT_O = ier_q[7:0];
      SEL_IPRA: DAT_O = ipr_q[15:8];
      SEL_IPRB: DAT_O = ipr_q[7:0];
      SEL_ISRA: DAT_O = isr_q[15:8];
      SEL_ISRB: DAT_O = isr_q[7:0];
      SEL_IMRA: DAT_O = imr_q[15:8];
      SEL_IMRB: DAT_O = imr_q[7:0];
      SEL_VR:   DAT_O = vr_q;
      default:  DAT_O = 8'h00;
    endcase
  end

  assign IRQ_N     = irq_n_q;
  assign VEC_O     = vec_q;
  assign VEC_VALID = vec_valid_q;
  assign SPURIOUS  = spurious_q;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mfp_irq_ctrl
//   Self-checking bench for mfp_irq_ctrl. Directed scenarios from the
//   controller's intended use, followed by randomized traffic. A behavioural
//   model tracks the registers as plain 16-bit channel vectors and decides
//   each acknowledge with arithmetic priority (highest set bit via $clog2).
// -----------------------------------------------------------------------------
module tb_mfp_irq_ctrl;

  localparam logic [7:0] VR_RST = 8'h00;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  REG_SEL;
  logic        REG_WE;
  logic [7:0]  DAT_I;
  logic [7:0]  DAT_O;
  logic [15:0] IRQ_IN;
  logic        IACK;
  logic        IRQ_N;
  logic [7:0]  VEC_O;
  logic        VEC_VALID;
  logic        SPURIOUS;

  mfp_irq_ctrl #(.VR_RESET(VR_RST)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REG_SEL   (REG_SEL),
    .REG_WE    (REG_WE),
    .DAT_I     (DAT_I),
    .DAT_O     (DAT_O),
    .IRQ_IN    (IRQ_IN),
    .IACK      (IACK),
    .IRQ_N     (IRQ_N),
    .VEC_O     (VEC_O),
    .VEC_VALID (VEC_VALID),
    .SPURIOUS  (SPURIOUS)
  );

  initial CLK = 1'b0;
  always #50 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [15:0] m_ier, m_ipr, m_isr, m_imr, m_prev;
  logic [7:0]  m_vr, m_vec;
  logic        m_irq_n, m_valid, m_spur;

  // Index of the highest set bit, -1 for zero.
  function automatic int hsb(input logic [15:0] v);
    return $clog2(int'(v) + 1) - 1;
  endfunction

  function automatic logic [7:0] m_rd(input logic [3:0] sel);
    case (sel)
      4'd0: return m_ier[15:8];
      4'd1: return m_ier[7:0];
      4'd2: return m_ipr[15:8];
      4'd3: return m_ipr[7:0];
      4'd4: return m_isr[15:8];
      4'd5: return m_isr[7:0];
      4'd6: return m_imr[15:8];
      4'd7: return m_imr[7:0];
      4'd8: return m_vr;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ier = '0; m_ipr = '0; m_isr = '0; m_imr = '0; m_prev = '0;
    m_vr = VR_RST; m_vec = '0; m_irq_n = 1'b1; m_valid = 1'b0; m_spur = 1'b0;
  endtask

  // One clock of behaviour, using the inputs present at the edge.
  task automatic model_step();
    logic [15:0] ev, n_ier, n_ipr, n_isr, n_imr, mask;
    logic [7:0]  n_vr, n_vec;
    int          win, top;
    bit          q, s;
    ev  = IRQ_IN & ~m_prev;
    win = hsb(m_ipr & m_imr);
    top = hsb(m_isr);
    s   = m_vr[3];
    q   = (win >= 0) && (!s || win > top);
    n_ier = m_ier; n_ipr = m_ipr; n_isr = m_isr; n_imr = m_imr;
    n_vr = m_vr; n_vec = m_vec;
    if (IACK && q) begin
      n_ipr[win] = 1'b0;
      if (s) n_isr[win] = 1'b1;
      n_vec = m_vr[7:4] * 16 + win;
    end
    if (REG_WE) begin
      // Byte lane: even select = channels 15..8, odd select = 7..0.
      mask = REG_SEL[0] ? {8'hFF, DAT_I} : {DAT_I, 8'hFF};
      case (REG_SEL)
        4'd0, 4'd1: begin
          n_ier = REG_SEL[0] ? {m_ier[15:8], DAT_I} : {DAT_I, m_ier[7:0]};
          n_ipr = n_ipr & mask;
        end
        4'd2, 4'd3: n_ipr = n_ipr & mask;
        4'd4, 4'd5: n_isr = n_isr & mask;
        4'd6, 4'd7: n_imr = REG_SEL[0] ? {m_imr[15:8], DAT_I} : {DAT_I, m_imr[7:0]};
        4'd8: begin
          n_vr = DAT_I;
          if (!DAT_I[3]) n_isr = '0;
        end
        default: ;
      endcase
    end
    n_ipr = n_ipr | (ev & m_ier);
    m_irq_n = !q;
    m_valid = IACK && q;
    m_spur  = IACK && !q;
    m_ier = n_ier; m_ipr = n_ipr; m_isr = n_isr; m_imr = n_imr;
    m_vr = n_vr; m_vec = n_vec; m_prev = IRQ_IN;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic compare_all();
    check("irq_n", IRQ_N, m_irq_n);
    check("vec_valid", VEC_VALID, m_valid);
    check("spurious", SPURIOUS, m_spur);
    check("vec_o", VEC_O, m_vec);
    for (int s = 0; s < 16; s++) begin
      REG_SEL = 4'(s);
      #1;
      check($sformatf("rd_sel%0d", s), DAT_O, m_rd(4'(s)));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic cyc(input logic [15:0] irq, input logic iack, input logic we,
                     input logic [3:0] sel, input logic [7:0] dat);
    IRQ_IN = irq; IACK = iack; REG_WE = we; REG_SEL = sel; DAT_I = dat;
    tick();
  endtask

  task automatic idle();
    cyc(16'h0000, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic wr(input logic [3:0] sel, input logic [7:0] dat);
    cyc(16'h0000, 1'b0, 1'b1, sel, dat);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] sel, input logic [7:0] exp);
    REG_SEL = sel;
    #1;
    check(tag, DAT_O, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    RST_N = 1'b0; REG_SEL = '0; REG_WE = 1'b0; DAT_I = '0; IRQ_IN = '0; IACK = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    compare_all();
    check("rst_irq_n", IRQ_N, 1'b1);
    check("rst_vec_o", VEC_O, 8'h00);
    rd_check("rst_vr", 4'd8, VR_RST);

    // 1: single channel request and acknowledge
    wr(4'd0, 8'h20);
    wr(4'd6, 8'h20);
    wr(4'd8, 8'h40);
    cyc(16'h2000, 1'b0, 1'b0, 4'd0, 8'h00);
    rd_check("t1_ipra", 4'd2, 8'h20);
    idle();
    check("t1_irq_low", IRQ_N, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 4'd0, 8'h00);
    check("t1_valid", VEC_VALID, 1'b1);
    check("t1_vec", VEC_O, 8'h4D);
    rd_check("t1_ipra_clr", 4'd2, 8'h00);
    idle();
    check("t1_valid_drop", VEC_VALID, 1'b0);
    check("t1_irq_high", IRQ_N, 1'b1);

    // 2: software end-of-interrupt nesting
    wr(4'd8, 8'h48);
    wr(4'd1, 8'h20);
    wr(4'd7, 8'h20);
    cyc(16'h2020, 1'b0, 1'b0, 4'd0, 8'h00);
    idle();
    check("t2_irq_low", IRQ_N, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 4'd0, 8'h00);
    check("t2_vec13", VEC_O, 8'h4D);
    rd_check("t2_isra", 4'd4, 8'h20);
    idle();
    idle();
    check("t2_blocked", IRQ_N, 1'b1);
    rd_check("t2_iprb", 4'd3, 8'h20);
    wr(4'd4, 8'hDF);
    idle();
    check("t2_unblocked", IRQ_N, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 4'd0, 8'h00);
    check("t2_vec5", VEC_O, 8'h45);
    rd_check("t2_isrb", 4'd5, 8'h20);
    wr(4'd8, 8'h40);
    rd_check("t2_isr_s0", 4'd5, 8'h00);
    idle();

    // 3: masking and enable-clear
    wr(4'd7, 8'h00);
    wr(4'd1, 8'h01);
    cyc(16'h0001, 1'b0, 1'b0, 4'd0, 8'h00);
    idle();
    rd_check("t3_iprb", 4'd3, 8'h01);
    check("t3_masked", IRQ_N, 1'b1);
    wr(4'd7, 8'h01);
    idle();
    check("t3_unmasked", IRQ_N, 1'b0);
    wr(4'd1, 8'h00);
    rd_check("t3_iprb_clr", 4'd3, 8'h00);
    idle();
    check("t3_irq_high", IRQ_N, 1'b1);

    // 4: spurious acknowledge
    cyc(16'h0000, 1'b1, 1'b0, 4'd0, 8'h00);
    check("t4_spurious", SPURIOUS, 1'b1);
    check("t4_no_valid", VEC_VALID, 1'b0);
    check("t4_vec_keep", VEC_O, 8'h45);
    idle();
    check("t4_spur_drop", SPURIOUS, 1'b0);

    // 5: simultaneous event with clear / acknowledge
    cyc(16'h2000, 1'b0, 1'b1, 4'd2, 8'h00);
    rd_check("t5_set_wins", 4'd2, 8'h20);
    idle();
    cyc(16'h2000, 1'b1, 1'b0, 4'd0, 8'h00);
    check("t5_vec", VEC_O, 8'h4D);
    rd_check("t5_kept", 4'd2, 8'h20);
    idle();
    wr(4'd2, 8'h00);
    idle();

    // 6: asynchronous reset while a nested request is active
    wr(4'd8, 8'h48);
    wr(4'd0, 8'h60);
    wr(4'd6, 8'h60);
    cyc(16'h2000, 1'b0, 1'b0, 4'd0, 8'h00);
    idle();
    cyc(16'h0000, 1'b1, 1'b0, 4'd0, 8'h00);
    cyc(16'h4000, 1'b0, 1'b0, 4'd0, 8'h00);
    idle();
    check("t6_irq_low", IRQ_N, 1'b0);
    rd_check("t6_isra", 4'd4, 8'h20);
    IACK = 1'b1; REG_WE = 1'b0; IRQ_IN = '0;
    #10;
    RST_N = 1'b0;
    #1;
    model_reset();
    check("t6_irq_async", IRQ_N, 1'b1);
    check("t6_valid_rst", VEC_VALID, 1'b0);
    check("t6_vec_rst", VEC_O, 8'h00);
    for (int s = 0; s < 9; s++) begin
      REG_SEL = 4'(s);
      #1;
      check($sformatf("t6_reg%0d", s), DAT_O, (s == 8) ? VR_RST : 8'h00);
    end
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    IACK = 1'b0;
    idle();
    check("t6_no_valid", VEC_VALID, 1'b0);
    idle();

    // Randomized traffic
    begin
      logic [15:0] lvl;
      logic [7:0]  d;
      logic [3:0]  sel;
      lvl = '0;
      // Start from a usable configuration so requests actually flow.
      wr(4'd8, 8'h58);
      wr(4'd0, 8'hFF); wr(4'd1, 8'hFF);
      wr(4'd6, 8'hFF); wr(4'd7, 8'hFF);
      for (int n = 0; n < 800; n++) begin
        lvl = lvl ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
        sel = 4'($urandom_range(0, 15));
        d   = 8'($urandom);
        if (sel == 4'd8) d[3] = ($urandom_range(0, 4) != 0);
        // Keep enables and masks mostly open.
        if (sel <= 4'd1 || sel == 4'd6 || sel == 4'd7) d = d | 8'($urandom);
        cyc(lvl, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, sel, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
